// File: rtl/i2c_eeprom_pkg.sv
// Shared types and constants for the I2C serial-EEPROM responder.
package i2c_eeprom_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_DEV,
    ST_DEV_ACK,
    ST_WADDR,
    ST_WADDR_ACK,
    ST_WDATA,
    ST_WDATA_ACK,
    ST_RDATA,
    ST_RACK
  } state_e;

  localparam logic       ACK_BIT      = 1'b0;
  localparam logic       NACK_BIT     = 1'b1;
  localparam logic [6:0] DEF_DEV_ADDR = 7'h50;
  localparam logic       RW_WRITE     = 1'b0;
  localparam logic       RW_READ      = 1'b1;

endpackage

// File: rtl/i2c_bus_cond.sv
// Synchronises raw SCL/SDA and produces registered bus-event pulses
// (SCL rise/fall, START, STOP) plus the SDA level seen with each event.
module i2c_bus_cond #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic scl_i,
  input  logic sda_i,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_o,
  output logic stop_o,
  output logic sda_o
);

  logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
  logic scl_hist_q, sda_hist_q;
  logic scl_s, sda_s;
  logic scl_rise_q, scl_fall_q, start_q, stop_q, sda_q;

  assign scl_s = scl_sync_q[SYNC_STAGES-1];
  assign sda_s = sda_sync_q[SYNC_STAGES-1];

  // Flops reset to the idle-bus level so reset release never fakes an event.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_hist_q <= 1'b1;
      sda_hist_q <= 1'b1;
      scl_rise_q <= 1'b0;
      scl_fall_q <= 1'b0;
      start_q    <= 1'b0;
      stop_q     <= 1'b0;
      sda_q      <= 1'b1;
    end else begin
      scl_sync_q[0] <= scl_i;
      sda_sync_q[0] <= sda_i;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        scl_sync_q[i] <= scl_sync_q[i-1];
        sda_sync_q[i] <= sda_sync_q[i-1];
      end
      scl_hist_q <= scl_s;
      sda_hist_q <= sda_s;
      scl_rise_q <= scl_s & ~scl_hist_q;
      scl_fall_q <= ~scl_s & scl_hist_q;
      start_q    <= scl_s & scl_hist_q & sda_hist_q & ~sda_s;
      stop_q     <= scl_s & scl_hist_q & ~sda_hist_q & sda_s;
      sda_q      <= sda_s;
    end
  end

  assign scl_rise_o = scl_rise_q;
  assign scl_fall_o = scl_fall_q;
  assign start_o    = start_q;
  assign stop_o     = stop_q;
  assign sda_o      = sda_q;

endmodule

// File: rtl/i2c_eeprom_slave.sv
// 24C02-style I2C EEPROM responder: byte/page write, current, random and
// sequential read over an oversampled bus, open-drain SDA.
module i2c_eeprom_slave
  import i2c_eeprom_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR    = DEF_DEV_ADDR,
  parameter int         ADDR_W      = 8,
  parameter int         PAGE_W      = 3,
  parameter int         SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              RSTn,
  input  logic              scl_i,
  input  logic              sda_i,
  output logic              sda_oe,
  output logic              busy,
  output logic              wr_pulse,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data
);

  logic scl_rise, scl_fall, start_det, stop_det, sda_smp;

  i2c_bus_cond #(.SYNC_STAGES(SYNC_STAGES)) u_bus_cond (
    .clk_i      (clk),
    .rst_ni     (RSTn),
    .scl_i      (scl_i),
    .sda_i      (sda_i),
    .scl_rise_o (scl_rise),
    .scl_fall_o (scl_fall),
    .start_o    (start_det),
    .stop_o     (stop_det),
    .sda_o      (sda_smp)
  );

  state_e            state_q, state_d;
  logic [3:0]        bit_cnt_q, bit_cnt_d;
  logic [7:0]        shift_q, shift_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              rw_q, rw_d;
  logic              oe_q, oe_d;
  logic              busy_q, busy_d;
  logic              wr_pulse_q;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]        wr_data_q, wr_data_d;
  logic              mem_we;
  logic [7:0]        rx_byte, rd_byte;
  logic [PAGE_W-1:0] page_lo;
  logic [ADDR_W-1:0] ptr_page_inc;
  logic [7:0]        mem [2**ADDR_W];

  assign rx_byte      = {shift_q[6:0], sda_smp};
  assign rd_byte      = mem[ptr_q];
  assign page_lo      = ptr_q[PAGE_W-1:0] + PAGE_W'(1);
  assign ptr_page_inc = {ptr_q[ADDR_W-1:PAGE_W], page_lo};

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    ptr_d     = ptr_q;
    rw_d      = rw_q;
    oe_d      = oe_q;
    busy_d    = busy_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    mem_we    = 1'b0;

    if (start_det) begin
      state_d   = ST_DEV;
      bit_cnt_d = '0;
      oe_d      = 1'b0;
    end else if (stop_det) begin
      state_d = ST_IDLE;
      oe_d    = 1'b0;
      busy_d  = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: ;
        ST_DEV, ST_WADDR, ST_WDATA: begin
          if (scl_rise) begin
            shift_d   = rx_byte;
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              if (state_q == ST_DEV) begin
                if (rx_byte[7:1] == DEV_ADDR) begin
                  state_d = ST_DEV_ACK;
                  rw_d    = rx_byte[0];
                  busy_d  = 1'b1;
                end else begin
                  state_d = ST_IDLE;
                  busy_d  = 1'b0;
                end
              end else if (state_q == ST_WADDR) begin
                ptr_d   = rx_byte[ADDR_W-1:0];
                state_d = ST_WADDR_ACK;
              end else begin
                mem_we    = 1'b1;
                wr_addr_d = ptr_q;
                wr_data_d = rx_byte;
                ptr_d     = ptr_page_inc;
                state_d   = ST_WDATA_ACK;
              end
            end
          end
        end
        // bit_cnt==8 marks the fall ending bit 7; 0 marks the fall ending ACK.
        ST_DEV_ACK, ST_WADDR_ACK, ST_WDATA_ACK: begin
          if (scl_rise) begin
            bit_cnt_d = '0;
          end else if (scl_fall) begin
            if (bit_cnt_q == 4'd8) begin
              oe_d = 1'b1;
            end else begin
              oe_d      = 1'b0;
              bit_cnt_d = '0;
              if (state_q == ST_DEV_ACK && rw_q == RW_READ) begin
                state_d = ST_RDATA;
                shift_d = rd_byte;
                oe_d    = ~rd_byte[7];
              end else if (state_q == ST_DEV_ACK && rw_q == RW_WRITE) begin
                state_d = ST_WADDR;
              end else begin
                state_d = ST_WDATA;
              end
            end
          end
        end
        ST_RDATA: begin
          if (scl_rise) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall) begin
            if (bit_cnt_q == 4'd8) begin
              oe_d    = 1'b0;
              state_d = ST_RACK;
            end else begin
              shift_d = {shift_q[6:0], 1'b0};
              oe_d    = ~shift_q[6];
            end
          end
        end
        ST_RACK: begin
          if (scl_rise) begin
            if (sda_smp == NACK_BIT) begin
              state_d = ST_IDLE;
              busy_d  = 1'b0;
            end else begin
              ptr_d     = ptr_q + ADDR_W'(1);
              bit_cnt_d = '0;
            end
          end else if (scl_fall) begin
            state_d = ST_RDATA;
            shift_d = rd_byte;
            oe_d    = ~rd_byte[7];
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      ptr_q      <= '0;
      rw_q       <= 1'b0;
      oe_q       <= 1'b0;
      busy_q     <= 1'b0;
      wr_pulse_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      ptr_q      <= ptr_d;
      rw_q       <= rw_d;
      oe_q       <= oe_d;
      busy_q     <= busy_d;
      wr_pulse_q <= mem_we;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
    end
  end

  // Storage keeps its contents across reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem[ptr_q] <= rx_byte;
  end

  assign sda_oe   = oe_q;
  assign busy     = busy_q;
  assign wr_pulse = wr_pulse_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;

endmodule

// File: tb/tb_i2c_eeprom_slave.sv
// Bench for i2c_eeprom_slave: bus-level master tasks plus an array model of the EEPROM.
`timescale 1ns/1ps
module tb_i2c_eeprom_slave;

  localparam int Q = 100;

  logic       clk = 1'b0;
  logic       RSTn = 1'b1;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_line;
  logic       sda_oe, busy, wr_pulse;
  logic [7:0] wr_addr, wr_data;

  assign sda_line = sda_m & ~sda_oe;

  i2c_eeprom_slave dut (
    .clk      (clk),
    .RSTn     (RSTn),
    .scl_i    (scl_m),
    .sda_i    (sda_line),
    .sda_oe   (sda_oe),
    .busy     (busy),
    .wr_pulse (wr_pulse),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data)
  );

  always #10 clk = ~clk;

  logic [15:0] wr_seen[$];
  int          oe_cnt = 0;
  always @(negedge clk) begin
    if (wr_pulse) wr_seen.push_back({wr_addr, wr_data});
    if (sda_oe) oe_cnt++;
  end

  logic [7:0]  mem_m [256];
  bit          wr_m  [256];
  int          ptr_m = 0;
  logic [15:0] exp_wr[$];
  int          wr_rd = 0;
  logic [7:0]  wbuf [16];
  logic [7:0]  rbuf [16];
  int          n_checks = 0;
  int          n_fail = 0;

  function automatic int page_next(input int a);
    return (a & 32'hF8) | ((a + 1) & 7);
  endfunction

  task automatic bus_start();
    sda_m = 1'b1; #(Q); scl_m = 1'b1; #(Q); sda_m = 1'b0; #(Q); scl_m = 1'b0; #(Q);
  endtask

  task automatic bus_stop();
    sda_m = 1'b0; #(Q); scl_m = 1'b1; #(Q); sda_m = 1'b1; #(Q);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) begin
      sda_m = b[i]; #(Q); scl_m = 1'b1; #(2*Q); scl_m = 1'b0; #(Q);
    end
    sda_m = 1'b1; #(Q); scl_m = 1'b1; #(Q); ack = ~sda_line; #(Q); scl_m = 1'b0; #(Q);
  endtask

  task automatic recv_byte(input logic m_ack, output logic [7:0] b);
    sda_m = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      #(Q); scl_m = 1'b1; #(Q); b[i] = sda_line; #(Q); scl_m = 1'b0; #(Q);
    end
    sda_m = m_ack ? 1'b0 : 1'b1; #(Q); scl_m = 1'b1; #(2*Q); scl_m = 1'b0; #(Q);
    sda_m = 1'b1;
  endtask

  // Full write transaction; model is updated with the spec's page-wrap rule.
  task automatic xfer_write(input logic [7:0] waddr, input int n, output int nacks);
    logic ack;
    nacks = 0;
    bus_start();
    send_byte(8'hA0, ack); if (!ack) nacks++;
    send_byte(waddr, ack); if (!ack) nacks++;
    for (int i = 0; i < n; i++) begin
      send_byte(wbuf[i], ack); if (!ack) nacks++;
    end
    bus_stop(); #(Q);
    ptr_m = int'(waddr);
    for (int i = 0; i < n; i++) begin
      mem_m[ptr_m] = wbuf[i];
      wr_m[ptr_m]  = 1'b1;
      exp_wr.push_back({8'(ptr_m), wbuf[i]});
      ptr_m = page_next(ptr_m);
    end
  endtask

  task automatic xfer_read(input bit set_addr, input logic [7:0] waddr, input int n,
                           output int nacks);
    logic ack;
    nacks = 0;
    bus_start();
    if (set_addr) begin
      send_byte(8'hA0, ack); if (!ack) nacks++;
      send_byte(waddr, ack); if (!ack) nacks++;
      bus_start();
    end
    send_byte(8'hA1, ack); if (!ack) nacks++;
    for (int i = 0; i < n; i++) recv_byte(i < n - 1, rbuf[i]);
    bus_stop(); #(Q);
  endtask

  task automatic test_reset();
    scl_m = 1'b1; sda_m = 1'b1; RSTn = 1'b0; #(200);
    n_checks++; if (sda_oe !== 1'b0) begin n_fail++; $display("FAIL reset_sda_oe: got %b want 0", sda_oe); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (wr_pulse !== 1'b0) begin n_fail++; $display("FAIL reset_wr_pulse: got %b want 0", wr_pulse); end
    n_checks++; if (wr_addr !== 8'h00) begin n_fail++; $display("FAIL reset_wr_addr: got %h want 00", wr_addr); end
    n_checks++; if (wr_data !== 8'h00) begin n_fail++; $display("FAIL reset_wr_data: got %h want 00", wr_data); end
    RSTn = 1'b1; #(400);
    n_checks++; if (sda_oe !== 1'b0) begin n_fail++; $display("FAIL post_reset_sda_oe: got %b want 0", sda_oe); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL post_reset_busy: got %b want 0", busy); end
    n_checks++; if (wr_seen.size() !== 0) begin n_fail++; $display("FAIL post_reset_wr_pulse: got %0d pulses want 0", wr_seen.size()); end
    ptr_m = 0;
  endtask

  task automatic test_single_write();
    logic ack;
    bus_start();
    send_byte(8'hA0, ack);
    n_checks++; if (ack !== 1'b1) begin n_fail++; $display("FAIL sw_ack_dev: got %b want 1", ack); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL sw_busy: got %b want 1", busy); end
    send_byte(8'h10, ack);
    n_checks++; if (ack !== 1'b1) begin n_fail++; $display("FAIL sw_ack_addr: got %b want 1", ack); end
    send_byte(8'h5A, ack);
    n_checks++; if (ack !== 1'b1) begin n_fail++; $display("FAIL sw_ack_data: got %b want 1", ack); end
    bus_stop(); #(Q);
    mem_m[8'h10] = 8'h5A; wr_m[8'h10] = 1'b1; exp_wr.push_back(16'h105A); ptr_m = page_next(8'h10);
    n_checks++; if (wr_seen.size() !== exp_wr.size()) begin n_fail++; $display("FAIL sw_pulse_count: got %0d want %0d", wr_seen.size(), exp_wr.size()); end
    for (int i = wr_rd; i < exp_wr.size(); i++) begin
      n_checks++;
      if (i >= wr_seen.size() || wr_seen[i] !== exp_wr[i]) begin n_fail++; $display("FAIL sw_commit[%0d]: got %h want %h", i, wr_seen[i], exp_wr[i]); end
    end
    wr_rd = exp_wr.size();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL sw_busy_after_stop: got %b want 0", busy); end
  endtask

  task automatic test_random_read();
    logic ack;
    logic [7:0] d;
    bus_start();
    send_byte(8'hA0, ack); send_byte(8'h10, ack);
    bus_start();
    send_byte(8'hA1, ack);
    n_checks++; if (ack !== 1'b1) begin n_fail++; $display("FAIL rr_ack_read: got %b want 1", ack); end
    recv_byte(1'b0, d);
    ptr_m = 8'h10;
    n_checks++; if (d !== mem_m[ptr_m]) begin n_fail++; $display("FAIL rr_data: got %h want %h", d, mem_m[ptr_m]); end
    n_checks++; if (sda_oe !== 1'b0) begin n_fail++; $display("FAIL rr_release: got %b want 0", sda_oe); end
    bus_stop(); #(Q);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rr_busy: got %b want 0", busy); end
  endtask

  task automatic test_page_write();
    int nacks;
    wbuf[0] = 8'h11; wbuf[1] = 8'h22; wbuf[2] = 8'h33;
    xfer_write(8'h06, 3, nacks);
    n_checks++; if (nacks !== 0) begin n_fail++; $display("FAIL pw_acks: got %0d missing want 0", nacks); end
    for (int i = 0; i < 2; i++) wbuf[i] = 8'($urandom);
    xfer_write(8'hFE, 2, nacks);
    n_checks++; if (nacks !== 0) begin n_fail++; $display("FAIL pw_fe_acks: got %0d missing want 0", nacks); end
    for (int k = 0; k < 3; k++) begin
      int n;
      n = $urandom_range(1, 10);
      for (int i = 0; i < n; i++) wbuf[i] = 8'($urandom);
      xfer_write(8'($urandom_range(0, 255)), n, nacks);
      n_checks++; if (nacks !== 0) begin n_fail++; $display("FAIL pw_rand_acks: got %0d missing want 0", nacks); end
    end
    n_checks++; if (wr_seen.size() !== exp_wr.size()) begin n_fail++; $display("FAIL pw_pulse_count: got %0d want %0d", wr_seen.size(), exp_wr.size()); end
    for (int i = wr_rd; i < exp_wr.size(); i++) begin
      n_checks++;
      if (i >= wr_seen.size() || wr_seen[i] !== exp_wr[i]) begin n_fail++; $display("FAIL pw_commit[%0d]: got %h want %h", i, wr_seen[i], exp_wr[i]); end
    end
    wr_rd = exp_wr.size();
  endtask

  task automatic test_seq_read();
    int nacks;
    xfer_read(1'b1, 8'hFE, 4, nacks);
    n_checks++; if (nacks !== 0) begin n_fail++; $display("FAIL sr_acks: got %0d missing want 0", nacks); end
    ptr_m = 8'hFE;
    for (int i = 0; i < 4; i++) begin
      if (wr_m[ptr_m]) begin
        n_checks++;
        if (rbuf[i] !== mem_m[ptr_m]) begin n_fail++; $display("FAIL sr_data[%02h]: got %h want %h", ptr_m, rbuf[i], mem_m[ptr_m]); end
      end
      if (i < 3) ptr_m = (ptr_m + 1) % 256;
    end
  endtask

  task automatic test_wrong_addr();
    logic ack;
    int   oe_base, nw, nacks;
    oe_base = oe_cnt; nw = wr_seen.size();
    bus_start();
    send_byte(8'hA2, ack);
    n_checks++; if (ack !== 1'b0) begin n_fail++; $display("FAIL wa_no_ack: got %b want 0", ack); end
    send_byte(8'($urandom), ack);
    bus_stop(); #(Q);
    n_checks++; if (oe_cnt !== oe_base) begin n_fail++; $display("FAIL wa_sda_oe: got %0d driven cycles want 0", oe_cnt - oe_base); end
    n_checks++; if (wr_seen.size() !== nw) begin n_fail++; $display("FAIL wa_wr_pulse: got %0d pulses want %0d", wr_seen.size(), nw); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL wa_busy: got %b want 0", busy); end
    wbuf[0] = 8'($urandom);
    xfer_write(8'($urandom_range(0, 255)), 1, nacks);
    n_checks++; if (nacks !== 0) begin n_fail++; $display("FAIL wa_next_acks: got %0d missing want 0", nacks); end
    for (int i = wr_rd; i < exp_wr.size(); i++) begin
      n_checks++;
      if (i >= wr_seen.size() || wr_seen[i] !== exp_wr[i]) begin n_fail++; $display("FAIL wa_commit[%0d]: got %h want %h", i, wr_seen[i], exp_wr[i]); end
    end
    wr_rd = exp_wr.size();
  endtask

  task automatic test_no_data_write();
    int nacks, nw, a;
    a = 8'h10;
    for (int t = 0; t < 64; t++) begin
      int c;
      c = $urandom_range(0, 255);
      if (wr_m[c]) begin a = c; break; end
    end
    nw = wr_seen.size();
    xfer_write(8'(a), 0, nacks);
    n_checks++; if (nacks !== 0) begin n_fail++; $display("FAIL nd_acks: got %0d missing want 0", nacks); end
    n_checks++; if (wr_seen.size() !== nw) begin n_fail++; $display("FAIL nd_wr_pulse: got %0d pulses want %0d", wr_seen.size(), nw); end
    xfer_read(1'b0, 8'h00, 1, nacks);
    n_checks++; if (nacks !== 0) begin n_fail++; $display("FAIL nd_read_ack: got %0d missing want 0", nacks); end
    n_checks++; if (rbuf[0] !== mem_m[a]) begin n_fail++; $display("FAIL nd_cur_read: got %h want %h", rbuf[0], mem_m[a]); end
  endtask

  task automatic test_reset_mid_read();
    logic ack;
    int   nacks, a;
    a = $urandom_range(16, 255);
    wbuf[0] = 8'($urandom) & 8'h7F;
    xfer_write(8'(a), 1, nacks);
    wr_rd = exp_wr.size();
    bus_start();
    send_byte(8'hA0, ack); send_byte(8'(a), ack);
    bus_start();
    send_byte(8'hA1, ack);
    #(Q/2);
    n_checks++; if (sda_oe !== 1'b1) begin n_fail++; $display("FAIL rm_driving: got %b want 1", sda_oe); end
    RSTn = 1'b0; #1;
    n_checks++; if (sda_oe !== 1'b0) begin n_fail++; $display("FAIL rm_async_release: got %b want 0", sda_oe); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rm_busy: got %b want 0", busy); end
    #(Q); RSTn = 1'b1; ptr_m = 0;
    #(Q); scl_m = 1'b1; #(Q);
    xfer_read(1'b0, 8'h00, 1, nacks);
    n_checks++; if (nacks !== 0) begin n_fail++; $display("FAIL rm_read_ack: got %0d missing want 0", nacks); end
    n_checks++; if (rbuf[0] !== mem_m[0]) begin n_fail++; $display("FAIL rm_read_ptr0: got %h want %h", rbuf[0], mem_m[0]); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rm_busy_end: got %b want 0", busy); end
  endtask

  initial begin
    #3;
    test_reset();
    test_single_write();
    test_random_read();
    test_page_write();
    test_seq_read();
    test_wrong_addr();
    test_no_data_write();
    test_reset_mid_read();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
